// File: rtl/imem_program_writer.sv
// imem_program_writer: encodes symbolic instruction beats and writes them to consecutive imem addresses
// Ports: clk/rst_n (sync active-low); start/base_addr open a program; finish closes it;
// in_valid/in_ready handshake with op_sel, rs, rt, rd, shamt, funct, imm, target fields;
// imem_we/imem_addr/imem_wdata drive the memory write port; words, busy, done, full, err_illegal report status.
module imem_program_writer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err_illegal
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, FULL} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] next_addr;
  logic accept, legal, last;
  logic [31:0] enc;
  assign in_ready = state == LOAD;
  assign busy     = state == LOAD;
  assign done     = state == DONE;
  assign full     = state == FULL;
  assign accept   = in_ready && in_valid;
  assign legal    = op_sel <= 4'd8;
  assign last     = &next_addr;
  // I-type opcodes are 1000_00 + (op_sel-1), so addi..bne map to 100000..100110
  always_comb begin
    enc = 32'd0;
    if (op_sel == 4'd0) enc = {6'b000000, rs, rt, rd, shamt, funct};
    else if (op_sel == 4'd8) enc = {6'b111111, target};
    else if (legal) enc = {3'b100, op_sel[2:0] - 3'd1, rs, rt, imm};
  end
  // exhaustion outranks finish when the final address is consumed
  always_comb begin
    state_nx = state;
    if (state == LOAD) state_nx = (accept && legal && last) ? FULL : finish ? DONE : LOAD;
    else if (start) state_nx = LOAD;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      next_addr   <= '0;
      words       <= '0;
      err_illegal <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
    end else begin
      state   <= state_nx;
      imem_we <= 1'b0;
      if (state != LOAD && start) begin
        next_addr   <= base_addr;
        words       <= '0;
        err_illegal <= 1'b0;
      end else if (accept && legal) begin
        imem_we    <= 1'b1;
        imem_addr  <= next_addr;
        imem_wdata <= enc;
        next_addr  <= next_addr + 1'b1;
        words      <= words + 1'b1;
      end else if (accept) begin
        err_illegal <= 1'b1;
      end
    end
  end
endmodule

// File: doc/imem_program_writer.md
# imem_program_writer

Sequential instruction encoder and instruction-memory writer: accepts symbolic instruction requests over a valid/ready handshake, packs them into 32-bit words using the same opcode map the control unit decodes, and writes them to consecutive instruction-memory addresses. It is the producing end of the opcode interface. It sits between the test/boot loader and the instruction memory write port, ahead of the CPU fetch path.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a program at base_addr; sampled only in IDLE, DONE, FULL
- base_addr  in  ADDR_W  first write address
- finish  in  1  end of program; sampled only in LOAD
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- op_sel  in  4  0 rtype, 1 addi, 2 lw, 3 sw, 4 andi, 5 ori, 6 beq, 7 bne, 8 j, 9-15 illegal
- rs, rt, rd, shamt  in  5 each  register and shift fields
- funct  in  6  R-type function
- imm  in  16  immediate / branch offset
- target  in  26  jump target
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded instruction
- words  out  ADDR_W+1  words written since last start
- busy  out  1  state is LOAD
- done  out  1  state is DONE
- full  out  1  state is FULL
- err_illegal  out  1  sticky: an illegal op_sel was accepted since last start

## Operation
- Encoding: opcode in [31:26]. rtype 000000 with rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]. addi 100000, lw 100001, sw 100010, andi 100011, ori 100100, beq 100101, bne 100110: rs, rt, imm[15:0]. j 111111: target[25:0]. Fields unused by a format are zero regardless of inputs.
- States: IDLE, LOAD, DONE, FULL. Reset -> IDLE.
- IDLE/DONE/FULL: start=1 -> LOAD, next_addr<=base_addr, words<=0, err_illegal<=0, done/full clear.
- LOAD: in_ready=1. Accepted legal beat -> registered write next cycle at next_addr; next_addr<=next_addr+1 (mod 2^ADDR_W); words<=words+1.
- Accepted illegal beat: no write, no address/count change, err_illegal<=1.
- finish=1 in LOAD -> DONE. A beat accepted in the same cycle as finish is still written.
- Address exhaustion: when a legal beat is accepted with next_addr = 2^ADDR_W-1, write it, then go to FULL (in_ready=0). next_addr wraps to 0 but no further writes occur until start. finish in that cycle: FULL has priority.
- start ignored in LOAD; finish ignored outside LOAD.
- Reset mid-program: pending write is dropped (imem_we=0 the next cycle), all outputs return to reset values.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, words 0, busy 0, done 0, full 0, err_illegal 0.
- in_ready is a decode of state only (no combinational path from in_valid).
- Latency: beat accepted at edge N -> imem_we=1 with addr/wdata valid during cycle N+1, sampled by memory at edge N+1. imem_addr/imem_wdata hold last value when imem_we=0.
- Throughput: one word per cycle in LOAD; back-to-back writes at consecutive addresses.
- words and err_illegal update at the acceptance edge; done/full assert the edge after finish/last-address accept.
- start -> LOAD takes one edge; in_ready high the following cycle.

## Test plan
- Reset with rst_n=0 two cycles while in_valid=1 -> all outputs 0, no imem_we.
- start, base_addr=0x10; send addi rs=1 rt=2 imm=0x0005 -> imem_we at addr 0x10, wdata 0x80220005; words=1.
- Back-to-back lw rs=3 rt=4 imm=0xFFFC, rtype rs=1 rt=2 rd=3 funct=0x20, j target=0x0000040 -> addrs 0x11,0x12,0x13; wdata 0x8464FFFC, 0x00221820, 0xFC000040; junk on imm during rtype yields no change.
- op_sel=12 between two beq beats -> err_illegal=1, only beq words written at consecutive addresses, words=2.
- base_addr=0xFE, three legal beats -> writes at 0xFE, 0xFF; full=1, in_ready=0, third beat stalls; start restarts and clears full.
- finish with a beat in the same cycle -> that beat written, done=1 next cycle; start during LOAD ignored.
